// File: rtl/param_register_file.sv
// Parametrised two-read/one-write register file with a hardware clear sequencer,
// hardwired zero register, write-to-read bypass and stall-able registered read ports.
module param_register_file #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int ZERO_REG    = 31,
    parameter int BYPASS_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_2,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg_address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] reg_out_1,
    output logic [DATA_WIDTH-1:0] reg_out_2,
    output logic                  ready
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  write_ok;
    logic                  clear_done;
    logic [DATA_WIDTH-1:0] read_val_1, read_val_2;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear_done = 1'b0;
        if (state == CLEAR && cnt == LAST_ADDR) begin
            state_next = RUN;
            clear_done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            if (clear_done) ready <= 1'b1;
            else            cnt   <= cnt + ADDR_WIDTH'(1);
        end
    end

    // Writes to the zero register are discarded so it can never hold a stale value.
    assign write_ok = (state == RUN) && reg_write &&
                      !(ZERO_REG_EN != 0 && write_reg_address == ZERO_ADDR);

    // The array has no reset: the clear sequencer zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (write_ok)
                mem[write_reg_address] <= data;
        end
    end

    always_comb begin
        read_val_1 = mem[read_reg_address_1];
        if (ZERO_REG_EN != 0 && read_reg_address_1 == ZERO_ADDR)
            read_val_1 = '0;
        else if (BYPASS_EN != 0 && reg_write && write_reg_address == read_reg_address_1)
            read_val_1 = data;
    end

    always_comb begin
        read_val_2 = mem[read_reg_address_2];
        if (ZERO_REG_EN != 0 && read_reg_address_2 == ZERO_ADDR)
            read_val_2 = '0;
        else if (BYPASS_EN != 0 && reg_write && write_reg_address == read_reg_address_2)
            read_val_2 = data;
    end

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            reg_out_1 <= '0;
            reg_out_2 <= '0;
        end else if (rd_en) begin
            reg_out_1 <= read_val_1;
            reg_out_2 <= read_val_2;
        end
    end

endmodule
